// File: rtl/pack_writeback.sv
// Packs one pixel bit per result-RAM byte into 16-bit words and writes them to the output memory.
// Build option PACK_THRESH_EN: any nonzero byte packs as 1; otherwise only the byte LSB is used.
module pack_writeback #(
   parameter int NUM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   output logic        res_rd,
   output logic [13:0] res_addr,
   input  logic [7:0]  res_di,
   output logic        out_wr,
   output logic [9:0]  out_addr,
   output logic [15:0] out_do,
   output logic        pack_done
);

   typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

   localparam logic [9:0] LAST_WORD = 10'(NUM_WORDS - 1);

   state_t      r_state;
   logic [9:0]  r_word_cnt;
   logic [3:0]  r_bit_cnt;
   logic [15:0] r_shreg;
   logic        r_res_rd;
   logic [13:0] r_res_addr;
   logic        r_out_wr;
   logic [9:0]  r_out_addr;
   logic [15:0] r_out_do;
   logic        r_pack_done;

   logic        w_pix;
   logic [15:0] w_shreg_nxt;

`ifdef PACK_THRESH_EN
   assign w_pix = (res_di != 8'd0);
`else
   logic w_unused_di;
   assign w_unused_di = &{1'b0, res_di[7:1]};
   assign w_pix       = res_di[0];
`endif

   // First pixel of a word is shifted in first, so it ends up in bit 15.
   assign w_shreg_nxt = {r_shreg[14:0], w_pix};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_word_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_res_rd    <= 1'b0;
         r_res_addr  <= '0;
         r_out_wr    <= 1'b0;
         r_out_addr  <= '0;
         r_out_do    <= '0;
         r_pack_done <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state     <= RD;
                  r_word_cnt  <= '0;
                  r_bit_cnt   <= '0;
                  r_shreg     <= '0;
                  r_res_rd    <= 1'b1;
                  r_res_addr  <= '0;
                  r_pack_done <= 1'b0;
               end
            end
            RD: begin
               // Read data lags the address by one cycle, so bit 0 has nothing to capture yet.
               if (r_bit_cnt != 4'd0) begin
                  r_shreg <= w_shreg_nxt;
               end
               if (r_bit_cnt == 4'd15) begin
                  r_state  <= LAST;
                  r_res_rd <= 1'b0;
               end else begin
                  r_bit_cnt  <= r_bit_cnt + 4'd1;
                  r_res_addr <= {r_word_cnt, r_bit_cnt + 4'd1};
               end
            end
            LAST: begin
               r_shreg    <= w_shreg_nxt;
               r_out_wr   <= 1'b1;
               r_out_addr <= r_word_cnt;
               r_out_do   <= w_shreg_nxt;
               r_state    <= WR;
            end
            WR: begin
               r_out_wr <= 1'b0;
               if (r_word_cnt == LAST_WORD) begin
                  r_state     <= DONE;
                  r_pack_done <= 1'b1;
               end else begin
                  r_state    <= RD;
                  r_word_cnt <= r_word_cnt + 10'd1;
                  r_bit_cnt  <= '0;
                  r_shreg    <= '0;
                  r_res_rd   <= 1'b1;
                  r_res_addr <= {r_word_cnt + 10'd1, 4'd0};
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign res_rd    = r_res_rd;
   assign res_addr  = r_res_addr;
   assign out_wr    = r_out_wr;
   assign out_addr  = r_out_addr;
   assign out_do    = r_out_do;
   assign pack_done = r_pack_done;

endmodule

// File: doc/pack_writeback.md
# pack_writeback

Packs the 8-bit-per-pixel result RAM back into 16-bit words, 16 pixels per word, and writes them sequentially into a word-addressed output memory. It is the reverse of the load path that expands each 16-bit source word into 16 one-pixel bytes. The block sits at the end of the processing chain. It starts once the result image is final and drives `pack_done` when the last word has been written.

## Interface
Parameters:
- `NUM_WORDS`, default 1024: number of output words to produce. Legal range is 1..1024. Pixels processed = 16 × `NUM_WORDS`.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; sampled only in IDLE or DONE.
- `res_rd`  out  1  result RAM read strobe.
- `res_addr`  out  14  result RAM byte address.
- `res_di`  in  8  result RAM read data; valid one cycle after the `res_rd`/`res_addr` cycle.
- `out_wr`  out  1  output memory write strobe; one-cycle pulse per word.
- `out_addr`  out  10  output memory word address.
- `out_do`  out  16  packed word; valid in the same cycle as `out_wr`.
- `pack_done`  out  1  high in DONE.

## Operation
- States: IDLE, RD, LAST, WR, DONE.
- Registers:
  - `word_cnt`, 10 bit.
  - `bit_cnt`, 4 bit.
  - `shreg`, 16 bit.
- IDLE:
  - All strobes are low.
  - `start` = 1 → RD, with `word_cnt` = 0, `bit_cnt` = 0 and `shreg` cleared.
- RD:
  - `res_rd` = 1.
  - `res_addr` = {`word_cnt`, `bit_cnt`}, i.e. `word_cnt` × 16 + `bit_cnt`.
  - Every cycle except the first of each word, the byte returned for the previous address is shifted into `shreg` LSB-side: `shreg` <= {`shreg`[14:0], pix}.
  - `bit_cnt` increments each cycle. When `bit_cnt` = 15 → LAST.
- LAST:
  - `res_rd` = 0.
  - Captures the 16th byte into `shreg`.
  - → WR.
- WR:
  - `out_wr` = 1.
  - `out_addr` = `word_cnt`.
  - `out_do` = `shreg`.
  - Bit order: the pixel at the lowest `res_addr` of the word lands in `out_do`[15]; the highest lands in `out_do`[0].
  - If `word_cnt` = `NUM_WORDS`−1 → DONE. Otherwise `word_cnt`+1, `bit_cnt` = 0 → RD.
- DONE:
  - `pack_done` = 1, held.
  - `start` = 1 restarts exactly as from IDLE and clears `pack_done` the next cycle.
- `start` is ignored in RD, LAST and WR.
- The pixel bit `pix` is derived from `res_di` as defined under Configuration.
- Counter arithmetic: there is no counter wrap in normal operation. `word_cnt` never exceeds `NUM_WORDS`−1, and `bit_cnt` rolls 15→0 only on the WR→RD transition.

## Timing
- Reset values, all forced asynchronously:
  - `res_rd`, `out_wr`, `pack_done` = 0.
  - `res_addr` = 0, `out_addr` = 0, `out_do` = 0.
  - State = IDLE.
- `start` sampled high at edge T → first `res_rd` is high in cycle T+1.
- Per word: 16 RD cycles + 1 LAST + 1 WR = 18 cycles.
- First `out_wr` occurs in cycle T+18.
- `pack_done` rises in cycle T + 18 × `NUM_WORDS` + 1.
- `out_addr` and `out_do` hold their last values outside WR. `out_wr` is the only write qualifier.
- `res_addr` holds its last value when `res_rd` = 0.
- Reset asserted mid-word:
  - Outputs clear immediately; a partial word is never written.
  - After `rstn` rises, the block waits in IDLE for a new `start`.
- `start` coincident with the DONE entry edge is ignored. It is only sampled once the block is in DONE.

## Configuration
- Macro `PACK_THRESH_EN`:
  - Defined: `pix` = (`res_di` != 8'd0). Any nonzero distance value packs as 1.
  - Undefined: `pix` = `res_di`[0]. Only the LSB is taken, matching a 0/1 byte image.
- No other behaviour or timing changes between the two builds.

## Test plan
- Reset then idle: `rstn` low for 3 cycles, no `start` → all outputs 0 for 50 cycles; `pack_done` = 0.
- Single word, `NUM_WORDS` = 1: RAM bytes 0..15 = 1,0,0,…,0,1 → one `out_wr` at T+18 with `out_addr` = 0, `out_do` = 16'h8001; `pack_done` rises at T+19.
- Full image, `NUM_WORDS` = 1024, alternating 0/1 bytes → 1024 writes, every `out_do` = 16'h5555, addresses 0..1023 in order; `pack_done` at T+18433.
- Threshold: bytes = 8'd2 everywhere → `out_do` = 16'hFFFF with `PACK_THRESH_EN` defined, 16'h0000 without.
- Mid-operation reset: `rstn` pulled low during word 5, bit 9 → outputs clear immediately, no write to `out_addr` 5. A new `start` rewrites from address 0.
- Restart from DONE: `start` in DONE → `pack_done` drops the next cycle and a second full pass produces identical writes.
